// File: rtl/mux4_arbiter.sv
// mux4_arbiter: 4-way round-robin arbiter driving a 4:1 mux selector.
// Optional hold-time preemption is compiled in with `define ARB_TIMEOUT_EN.
module mux4_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       expired
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e     state_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;

    logic [1:0] pick_d;
    logic       found_d;
    logic       release_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic       expired_q;
    logic       expire_d;
`endif

    // Pick first requester at or after ptr; lowest offset wins.
    always_comb begin
        logic [1:0] idx;
        pick_d  = '0;
        found_d = 1'b0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                pick_d  = idx;
                found_d = 1'b1;
            end
        end
    end

    // Owner gives up the grant by done or by dropping its request.
    assign release_d = done | ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
    assign expire_d = (cnt_q == HOLD_LAST);
`endif

    // Arbitration FSM with registered grant, selector and pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            expired_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            expired_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        gnt_q   <= 4'b0001 << pick_d;
                        sel_q   <= pick_d;
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= sel_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    end else if (expire_d) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        ptr_q     <= sel_q + 2'd1;
                        expired_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

`ifdef ARB_TIMEOUT_EN
    assign expired = expired_q;
`else
    assign expired = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed and random checks against a
// transaction-level round-robin model.
module tb_mux4_arbiter;

    localparam int TO = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       expired;

    int errors = 0;
    int checks = 0;

    // model: owner index or -1, next scan start, cycles held
    int m_owner;
    int m_ptr;
    int m_held;
    int m_sel;
    bit m_exp;

    mux4_arbiter #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_sel   = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_step();
        m_exp = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (req[j] && m_owner < 0) begin
                    m_owner = j;
                    m_sel   = j;
                    m_held  = 1;
                end
            end
        end else if (done || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (TO_EN && m_held >= TO) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_exp   = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        chk({tag, ".gnt"}, 8'(gnt), 8'(eg));
        chk({tag, ".sel"}, 8'(sel), 8'(m_sel));
        chk({tag, ".busy"}, 8'(busy), 8'(m_owner >= 0));
        chk({tag, ".exp"}, 8'(expired), 8'(m_exp));
    endtask

    // one clock: drive, edge, model, sample on falling edge
    task automatic cyc(input logic [3:0] r, input logic d,
                       input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] rr [5];
        rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100;
        rr[3] = 4'b1000; rr[4] = 4'b0001;
        req   = '0;
        done  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk_model("reset");
        do_reset();

        // single request then done; next scan starts at 2
        cyc(4'b0010, 1'b0, "single");
        chk("single.g", 8'(gnt), 8'h02);
        chk("single.s", 8'(sel), 8'h01);
        cyc(4'b0010, 1'b1, "single.done");
        chk("single.rel", 8'(gnt), 8'h00);
        cyc(4'b0011, 1'b0, "ptr2");
        chk("ptr2.g", 8'(gnt), 8'h01);
        cyc(4'b0011, 1'b1, "ptr2.done");

        // round robin with bubble between grants
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1'b0, "rr");
            chk("rr.g", 8'(gnt), 8'(rr[i]));
            chk("rr.s", 8'(sel), 8'(i % 4));
            cyc(4'b1111, 1'b1, "rr.done");
            chk("rr.bub", 8'(gnt), 8'h00);
        end

        // owner 2 holds through others, then drops its request
        do_reset();
        cyc(4'b0100, 1'b0, "drop");
        cyc(4'b1111, 1'b0, "drop.oth");
        chk("drop.sel", 8'(sel), 8'h02);
        cyc(4'b1011, 1'b0, "drop.rel");
        chk("drop.g", 8'(gnt), 8'h00);

        // wrap from ptr 3
        cyc(4'b1001, 1'b0, "wrap");
        chk("wrap.g3", 8'(gnt), 8'h08);
        cyc(4'b1001, 1'b1, "wrap.done");
        cyc(4'b1001, 1'b0, "wrap.0");
        chk("wrap.g0", 8'(gnt), 8'h01);
        cyc(4'b1001, 1'b1, "wrap.done2");

        // hold with done low: timeout or indefinite grant
        do_reset();
        for (int i = 0; i < 104; i++)
            cyc(4'b0001, 1'b0, "hold");
        if (!TO_EN) chk("hold.persist", 8'(gnt), 8'h01);

        // asynchronous reset mid-grant
        do_reset();
        cyc(4'b0100, 1'b0, "ar");
        chk("ar.g", 8'(gnt), 8'h04);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar.gnt", 8'(gnt), 8'h00);
        chk("ar.sel", 8'(sel), 8'h00);
        chk("ar.busy", 8'(busy), 8'h00);
        chk("ar.exp", 8'(expired), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1111, 1'b0, "ar.p0");
        chk("ar.p0g", 8'(gnt), 8'h01);

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc(4'($urandom), ($urandom % 4) == 0, "rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
